debounce_fsm: RTL and testbench

- Conditions a raw, asynchronous, bouncing input (push-button, switch, external strobe) into a clean, clock-synchronous level.
- Sits directly upstream of the edge detector: its `level` output drives the detector's `level` input.
- Contains a synchronizer chain followed by a 4-state stability FSM with a consecutive-sample counter.
- `level` changes only after the synchronized input has held a new value for STABLE_CYCLES consecutive clocks.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/level_sync.sv | 24 ++
 rtl/debounce_fsm.sv | 100 ++++++++++
 tb/tb_debounce_fsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
// State codes are chosen so bit 1 equals the debounced level.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/level_sync.sv
// Plain flop chain that brings an asynchronous level into the clk domain.
// STAGES clocks of latency; no logic between stages.
module level_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounces a raw input: synchronizer, then a 4-state FSM that needs STABLE_CYCLES
// matching samples before moving level; an interrupted qualification pulses bounce.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_in,
  output logic level,
  output logic busy,
  output logic bounce
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             bounce_nxt;

  level_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (noisy_in),
    .q    (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE_LO;
      cnt    <= '0;
      level  <= 1'b0;
      bounce <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      bounce <= bounce_nxt;
    end
  end

  // cnt counts matching samples already seen; the sample that hits CNT_LAST
  // completes the window, so the counter never reaches STABLE_CYCLES.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    bounce_nxt = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt  = IDLE_LO;
          bounce_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt  = IDLE_HI;
          bounce_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
      end
    endcase
    level_nxt = (state_nxt == IDLE_HI) || (state_nxt == WAIT_LO);
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm with default parameters (2 sync stages, 4 stable cycles).
module tb_debounce_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic noisy_in = 1'b0;
  logic level;
  logic busy;
  logic bounce;

  debounce_fsm #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .noisy_in(noisy_in),
    .level   (level),
    .busy    (busy),
    .bounce  (bounce)
  );

  always #5 clk = ~clk;

  // {rst, din, level, busy, bounce} for one clock edge
  typedef struct packed {
    logic rst;
    logic din;
    logic lvl;
    logic bsy;
    logic bnc;
  } vec_t;

  logic [2:0] sb[$];
  string      tq[$];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check_one();
    logic [2:0] e;
    logic [2:0] a;
    string      t;
    e = sb.pop_front();
    t = tq.pop_front();
    a = {level, busy, bounce};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: level/busy/bounce got %b want %b", t, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic [2:0] e, input string tag);
    @(negedge clk);
    reset    = r;
    noisy_in = d;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    check_one();
  endtask

  task automatic cmp_int(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Glitch pattern: high on edges 1, 4, 7, ... after reset release
  function automatic logic glitch_d(input int k);
    return (k >= 1) && ((k % 3) == 1);
  endfunction

  int   p_cnt;
  int   n_cnt;
  int   hi_run;
  int   min_run;
  logic lvl_d;

  task automatic tick(input logic d);
    @(negedge clk);
    reset    = 1'b0;
    noisy_in = d;
    @(posedge clk);
    #1;
    if (level && !lvl_d) p_cnt++;
    if (!level && lvl_d) begin
      n_cnt++;
      if (hi_run < min_run) min_run = hi_run;
    end
    hi_run = level ? hi_run + 1 : 0;
    lvl_d  = level;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[27];
    int   bnc_seen;

    tbl = '{
      // reset, then clean rising step
      5'b10000, 5'b10000, 5'b10000,
      5'b01000, 5'b01000, 5'b01010, 5'b01010, 5'b01010, 5'b01100, 5'b01100,
      // release path
      5'b00100, 5'b00100, 5'b00110, 5'b00110, 5'b00110, 5'b00000, 5'b00000,
      // high 2, low 1, then steady high: one bounce, late rise
      5'b01000, 5'b01000, 5'b00010, 5'b01010, 5'b01001,
      5'b01010, 5'b01010, 5'b01010, 5'b01100, 5'b01100
    };

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst, tbl[i].din, {tbl[i].lvl, tbl[i].bsy, tbl[i].bnc},
            $sformatf("tbl[%0d]", i));
    end

    // reset mid-qualification discards the count, then qualification restarts
    drive(1'b1, 1'b0, 3'b000, "midrst_reset0");
    drive(1'b1, 1'b0, 3'b000, "midrst_reset1");
    drive(1'b0, 1'b1, 3'b000, "midrst_e1");
    drive(1'b0, 1'b1, 3'b000, "midrst_e2");
    drive(1'b0, 1'b1, 3'b010, "midrst_e3");
    drive(1'b0, 1'b1, 3'b010, "midrst_e4");
    drive(1'b1, 1'b1, 3'b000, "midrst_abort");
    drive(1'b0, 1'b1, 3'b000, "midrst_r1");
    drive(1'b0, 1'b1, 3'b000, "midrst_r2");
    drive(1'b0, 1'b1, 3'b010, "midrst_r3");
    drive(1'b0, 1'b1, 3'b010, "midrst_r4");
    drive(1'b0, 1'b1, 3'b010, "midrst_r5");
    drive(1'b0, 1'b1, 3'b100, "midrst_r6");

    // single-cycle glitches every 3 cycles: busy follows the input two edges
    // later, bounce three edges later, level never moves
    drive(1'b1, 1'b0, 3'b000, "glitch_reset0");
    drive(1'b1, 1'b0, 3'b000, "glitch_reset1");
    bnc_seen = 0;
    for (int k = 1; k <= 99; k++) begin
      drive(1'b0, glitch_d(k), {1'b0, glitch_d(k - 2), glitch_d(k - 3)},
            $sformatf("glitch[%0d]", k));
      if (bounce) bnc_seen++;
    end
    cmp_int("glitch_bounce_count", bnc_seen, 32);

    // press and release, each with 5 bounces, seen through an edge detector
    p_cnt   = 0;
    n_cnt   = 0;
    hi_run  = 0;
    min_run = 1000;
    lvl_d   = level;
    for (int i = 0; i < 10; i++) tick((i % 2) == 0);
    for (int i = 0; i < 12; i++) tick(1'b1);
    cmp_int("chain_level_after_press", int'(level), 1);
    for (int i = 0; i < 10; i++) tick((i % 2) == 1);
    for (int i = 0; i < 12; i++) tick(1'b0);
    cmp_int("chain_p_edge_count", p_cnt, 1);
    cmp_int("chain_n_edge_count", n_cnt, 1);
    cmp_int("chain_level_final", int'(level), 0);
    n_vec++;
    if (min_run < 5) begin
      n_bad++;
      $display("FAIL chain_min_high_width: got %0d want >= 5", min_run);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
